// File: rtl/psum_acc_driver.sv
// -----------------------------------------------------------------------------
// psum_acc_driver
// Driving end of the partial-sum accumulator channel set, placed between the PE
// multiplier and the accumulator. For each output pixel it takes NUM_PROD
// products. For every product it sends a clear token to the accumulator, feeds
// the running sum on every product except the first, reads back the
// accumulator echo and adds the product to that echo. After the last product
// it emits the final partial sum downstream. Every channel is a valid/ready
// pair, and every output is driven straight from a flop.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   prod_valid/ready/data          product input from the multiplier
//   clr_valid/ready/data           clear token to the accumulator (1 = first product)
//   acc_in_valid/ready/data        running sum to the accumulator
//   acc_out_valid/ready/data       accumulator echo back to the driver
//   res_valid/ready/data           final partial sum downstream
//   mismatch                       sticky flag: echo differed from the expected value
// -----------------------------------------------------------------------------
module psum_acc_driver #(
    parameter int WIDTH    = 8,
    parameter int NUM_PROD = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [WIDTH-1:0] prod_data,
    output logic             clr_valid,
    input  logic             clr_ready,
    output logic             clr_data,
    output logic             acc_in_valid,
    input  logic             acc_in_ready,
    output logic [WIDTH-1:0] acc_in_data,
    input  logic             acc_out_valid,
    output logic             acc_out_ready,
    input  logic [WIDTH-1:0] acc_out_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             mismatch
);

    localparam int CNT_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PROD - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_CLR = 3'd1,
        ST_SEND_IN  = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_EMIT     = 3'd4
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic [WIDTH-1:0]   prod_r;
    logic               prod_ready_r;
    logic               clr_valid_r;
    logic               clr_data_r;
    logic               acc_in_valid_r;
    logic [WIDTH-1:0]   acc_in_data_r;
    logic               acc_out_ready_r;
    logic               res_valid_r;
    logic [WIDTH-1:0]   res_data_r;
    logic               mismatch_r;
    logic [WIDTH-1:0]   next_sum_s;
    logic [WIDTH-1:0]   exp_echo_s;

    // Unsigned add that either drops the carry or clamps at all-ones.
    function automatic logic [WIDTH-1:0] acc_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (SATURATE && full[WIDTH]) begin
            acc_add = {WIDTH{1'b1}};
        end else begin
            acc_add = full[WIDTH-1:0];
        end
    endfunction

    // The accumulator is the reference, so the new sum builds on its echo
    // rather than on the local copy.
    always_comb begin
        next_sum_s = acc_add(acc_out_data, prod_r);
        if (cnt_r == {CNT_W{1'b0}}) begin
            exp_echo_s = {WIDTH{1'b0}};
        end else begin
            exp_echo_s = sum_r;
        end
    end

    // Pixel sequencing FSM; every handshake output is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            sum_r           <= {WIDTH{1'b0}};
            prod_r          <= {WIDTH{1'b0}};
            prod_ready_r    <= 1'b0;
            clr_valid_r     <= 1'b0;
            clr_data_r      <= 1'b0;
            acc_in_valid_r  <= 1'b0;
            acc_in_data_r   <= {WIDTH{1'b0}};
            acc_out_ready_r <= 1'b0;
            res_valid_r     <= 1'b0;
            res_data_r      <= {WIDTH{1'b0}};
            mismatch_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // prod_ready comes up one cycle after reset and is held until a product lands.
                    if (prod_valid && prod_ready_r) begin
                        prod_r       <= prod_data;
                        prod_ready_r <= 1'b0;
                        clr_valid_r  <= 1'b1;
                        clr_data_r   <= (cnt_r == {CNT_W{1'b0}});
                        state_r      <= ST_SEND_CLR;
                    end else begin
                        prod_ready_r <= 1'b1;
                    end
                end
                ST_SEND_CLR: begin
                    if (clr_ready) begin
                        clr_valid_r <= 1'b0;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            acc_out_ready_r <= 1'b1;
                            state_r         <= ST_WAIT_OUT;
                        end else begin
                            acc_in_valid_r <= 1'b1;
                            acc_in_data_r  <= sum_r;
                            state_r        <= ST_SEND_IN;
                        end
                    end else begin
                        state_r <= ST_SEND_CLR;
                    end
                end
                ST_SEND_IN: begin
                    if (acc_in_ready) begin
                        acc_in_valid_r  <= 1'b0;
                        acc_out_ready_r <= 1'b1;
                        state_r         <= ST_WAIT_OUT;
                    end else begin
                        state_r <= ST_SEND_IN;
                    end
                end
                ST_WAIT_OUT: begin
                    if (acc_out_valid) begin
                        acc_out_ready_r <= 1'b0;
                        mismatch_r      <= mismatch_r | (acc_out_data != exp_echo_s);
                        sum_r           <= next_sum_s;
                        if (cnt_r == CNT_LAST) begin
                            res_valid_r <= 1'b1;
                            res_data_r  <= next_sum_s;
                            state_r     <= ST_EMIT;
                        end else begin
                            cnt_r        <= cnt_r + CNT_W'(1);
                            prod_ready_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_WAIT_OUT;
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid_r  <= 1'b0;
                        cnt_r        <= {CNT_W{1'b0}};
                        sum_r        <= {WIDTH{1'b0}};
                        prod_ready_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    cnt_r           <= {CNT_W{1'b0}};
                    sum_r           <= {WIDTH{1'b0}};
                    prod_ready_r    <= 1'b0;
                    clr_valid_r     <= 1'b0;
                    acc_in_valid_r  <= 1'b0;
                    acc_out_ready_r <= 1'b0;
                    res_valid_r     <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready    = prod_ready_r;
    assign clr_valid     = clr_valid_r;
    assign clr_data      = clr_data_r;
    assign acc_in_valid  = acc_in_valid_r;
    assign acc_in_data   = acc_in_data_r;
    assign acc_out_ready = acc_out_ready_r;
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign mismatch      = mismatch_r;

endmodule

// File: tb/tb_psum_acc_driver.sv
// -----------------------------------------------------------------------------
// tb_psum_acc_driver
// Three driver instances, all with WIDTH=8:
//   0: NUM_PROD=5, wrapping add
//   1: NUM_PROD=2, saturating add
//   2: NUM_PROD=1, wrapping add
// The bench plays the multiplier, the accumulator and the downstream consumer.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_psum_acc_driver;

    localparam int NP   [3] = '{5, 2, 1};
    localparam bit SATP [3] = '{1'b0, 1'b1, 1'b0};
    localparam int LIMIT    = 100;

    logic       clk;
    logic       rst_n;
    logic [2:0] prod_valid, prod_ready, clr_valid, clr_ready, clr_data;
    logic [2:0] acc_in_valid, acc_in_ready, acc_out_valid, acc_out_ready;
    logic [2:0] res_valid, res_ready, mismatch;
    logic [7:0] prod_data    [3];
    logic [7:0] acc_in_data  [3];
    logic [7:0] acc_out_data [3];
    logic [7:0] res_data     [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_mm [3];
    int acc_in_seen2 = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        psum_acc_driver #(
            .WIDTH    (8),
            .NUM_PROD (NP[g]),
            .SATURATE (SATP[g])
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .prod_valid    (prod_valid[g]),
            .prod_ready    (prod_ready[g]),
            .prod_data     (prod_data[g]),
            .clr_valid     (clr_valid[g]),
            .clr_ready     (clr_ready[g]),
            .clr_data      (clr_data[g]),
            .acc_in_valid  (acc_in_valid[g]),
            .acc_in_ready  (acc_in_ready[g]),
            .acc_in_data   (acc_in_data[g]),
            .acc_out_valid (acc_out_valid[g]),
            .acc_out_ready (acc_out_ready[g]),
            .acc_out_data  (acc_out_data[g]),
            .res_valid     (res_valid[g]),
            .res_ready     (res_ready[g]),
            .res_data      (res_data[g]),
            .mismatch      (mismatch[g])
        );
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which the single-product instance offers a running sum.
    always @(negedge clk) begin
        if (acc_in_valid[2]) acc_in_seen2 <= acc_in_seen2 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] madd(input int i, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] f;
        f = {1'b0, a} + {1'b0, b};
        if (SATP[i] && f[8]) return 8'hFF;
        return f[7:0];
    endfunction

    function automatic logic pick(input int i, input int sel);
        case (sel)
            0:       return prod_ready[i];
            1:       return clr_valid[i];
            2:       return acc_in_valid[i];
            3:       return acc_out_ready[i];
            4:       return res_valid[i];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] pickd(input int i, input int sel);
        case (sel)
            1:       return {7'd0, clr_data[i]};
            2:       return acc_in_data[i];
            4:       return res_data[i];
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [31:0] outs(input int i);
        return {8'd0, prod_ready[i], clr_valid[i], clr_data[i], acc_in_valid[i],
                acc_out_ready[i], res_valid[i], mismatch[i], 1'b0, acc_in_data[i], res_data[i]};
    endfunction

    task automatic wait_hi(input int i, input int sel, input string tag);
        int t;
        t = 0;
        while (!pick(i, sel) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, " wait"}, {31'd0, pick(i, sel)}, 32'd1);
    endtask

    // Hold ready low for a few cycles while checking the offered token stays put.
    task automatic stall_hold(input int i, input int sel, input bit stall, input string tag);
        logic [7:0] d;
        int n;
        d = pickd(i, sel);
        n = stall ? int'($urandom_range(0, 3)) : 0;
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            check_val({tag, " hold"}, {23'd0, pick(i, sel), pickd(i, sel)}, {23'd0, 1'b1, d});
        end
    endtask

    task automatic idle_cycles(input bit stall);
        int n;
        n = stall ? int'($urandom_range(0, 3)) : 0;
        for (int s = 0; s < n; s++) @(negedge clk);
    endtask

    // One output pixel through instance i; products packed low byte first.
    task automatic run_pixel(input int i, input logic [39:0] p, input int n, input bit stall,
                             input bit fault, input int abort_at, input logic [7:0] exp_res);
        logic [7:0] msum, echo, pk;
        bit aborted;
        msum = 8'd0;
        aborted = 1'b0;
        for (int k = 0; k < n && !aborted; k++) begin
            pk = p[8*k +: 8];
            idle_cycles(stall);
            prod_valid[i] = 1'b1;
            prod_data[i]  = pk;
            wait_hi(i, 0, "prod");
            @(negedge clk);
            prod_valid[i] = 1'b0;
            check_val("prod_ready drop", {31'd0, prod_ready[i]}, 32'd0);

            wait_hi(i, 1, "clr");
            check_val("clr_data", {31'd0, clr_data[i]}, (k == 0) ? 32'd1 : 32'd0);
            stall_hold(i, 1, stall, "clr");
            clr_ready[i] = 1'b1;
            @(negedge clk);
            clr_ready[i] = 1'b0;
            check_val("clr drop", {31'd0, clr_valid[i]}, 32'd0);

            if (k > 0) begin
                wait_hi(i, 2, "acc_in");
                if (k == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_val("reset outputs", outs(i), 32'd0);
                    prod_valid[i] = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int j = 0; j < 3; j++) exp_mm[j] = 1'b0;
                    aborted = 1'b1;
                end else begin
                    check_val("acc_in_data", {24'd0, acc_in_data[i]}, {24'd0, msum});
                    stall_hold(i, 2, stall, "acc_in");
                    acc_in_ready[i] = 1'b1;
                    @(negedge clk);
                    acc_in_ready[i] = 1'b0;
                    check_val("acc_in drop", {31'd0, acc_in_valid[i]}, 32'd0);
                end
            end

            if (!aborted) begin
                echo = (k == 0) ? (fault ? 8'd7 : 8'd0) : msum;
                if (echo != ((k == 0) ? 8'd0 : msum)) exp_mm[i] = 1'b1;
                idle_cycles(stall);
                acc_out_valid[i] = 1'b1;
                acc_out_data[i]  = echo;
                wait_hi(i, 3, "acc_out");
                @(negedge clk);
                acc_out_valid[i] = 1'b0;
                check_val("acc_out_ready drop", {31'd0, acc_out_ready[i]}, 32'd0);
                check_val("mismatch", {31'd0, mismatch[i]}, {31'd0, exp_mm[i]});
                msum = madd(i, echo, pk);
            end
        end
        if (!aborted) begin
            wait_hi(i, 4, "res");
            check_val("res_data", {24'd0, res_data[i]}, {24'd0, exp_res});
            stall_hold(i, 4, stall, "res");
            res_ready[i] = 1'b1;
            @(negedge clk);
            res_ready[i] = 1'b0;
            check_val("res drop", {31'd0, res_valid[i]}, 32'd0);
        end
    endtask

    // Safety net against a hung handshake.
    initial begin
        #2000000;
        $display("FAIL global timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    // Directed scenarios.
    initial begin
        rst_n = 1'b0;
        prod_valid = 3'd0; clr_ready = 3'd0; acc_in_ready = 3'd0;
        acc_out_valid = 3'd0; res_ready = 3'd0;
        for (int j = 0; j < 3; j++) begin
            prod_data[j]    = 8'd0;
            acc_out_data[j] = 8'd0;
            exp_mm[j]       = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) check_val("reset state", outs(j), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal accumulator, products 1..5.
        run_pixel(0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 1'b0, 1'b0, -1, 8'd15);
        // Wrap-around: 200+100 mod 256.
        run_pixel(0, {8'd0, 8'd0, 8'd0, 8'd100, 8'd200}, 5, 1'b0, 1'b0, -1, 8'd44);
        // Saturating instance: clamps, stays clamped, and adds normally below the limit.
        run_pixel(1, {24'd0, 8'd100, 8'd200}, 2, 1'b0, 1'b0, -1, 8'd255);
        run_pixel(1, {24'd0, 8'd1, 8'd255}, 2, 1'b0, 1'b0, -1, 8'd255);
        run_pixel(1, {24'd0, 8'd20, 8'd10}, 2, 1'b0, 1'b0, -1, 8'd30);
        // Random stalls on every channel.
        run_pixel(0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 1'b1, 1'b0, -1, 8'd15);
        run_pixel(0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 1'b1, 1'b0, -1, 8'd15);
        // Faulty accumulator echoes 7 after the clear.
        run_pixel(0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 1'b0, 1'b1, -1, 8'd22);
        // Reset while the third product's running sum is being offered.
        run_pixel(0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 1'b0, 1'b0, 2, 8'd0);
        run_pixel(0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 1'b0, 1'b0, -1, 8'd15);
        // Single product per pixel, back to back.
        run_pixel(2, {32'd0, 8'd9}, 1, 1'b0, 1'b0, -1, 8'd9);
        run_pixel(2, {32'd0, 8'd9}, 1, 1'b0, 1'b0, -1, 8'd9);
        check_val("no acc_in for NUM_PROD=1", acc_in_seen2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
